// File: rtl/vga_wr_buffer.sv
// Posted-write FIFO between the CPU store path and the VGA framebuffer.
// Buffered pixel writes drain in FIFO order, optionally only during vertical blanking.
module vga_wr_buffer #(
   parameter int DEPTH       = 8,
   parameter int ADDR_W      = 16,
   parameter bit VBLANK_ONLY = 1'b1
) (
   input  logic                       i_clk,
   input  logic                       i_reset,
   input  logic                       i_wrEn,
   input  logic [31:0]                i_pxlAddr,
   input  logic [31:0]                i_pxlData,
   input  logic                       i_vblank,
   input  logic                       i_fb_ready,
   output logic                       o_fb_valid,
   output logic [ADDR_W-1:0]          o_fb_addr,
   output logic [31:0]                o_fb_data,
   output logic                       o_full,
   output logic [$clog2(DEPTH):0]     o_count,
   output logic [7:0]                 o_dropCnt
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;

   state_t             state_q, state_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               full_q, full_d;
   logic [7:0]         drop_q, drop_d;

   logic [ADDR_W-1:0]  addr_mem [DEPTH];
   logic [31:0]        data_mem [DEPTH];

   logic               push, pop, gate;
   logic               unused_addr_bits;

   assign unused_addr_bits = ^{i_pxlAddr[31:ADDR_W+2], i_pxlAddr[1:0]};

   always_comb begin
      push     = i_wrEn && !full_q && !i_reset;
      pop      = (state_q == DRAIN) && i_fb_ready;
      gate     = !VBLANK_ONLY || i_vblank;
      count_d  = count_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      drop_d   = drop_q;
      state_d  = state_q;

      if (push && !pop)
         count_d = count_q + 1'b1;
      else if (pop && !push)
         count_d = count_q - 1'b1;
      full_d = (count_d == CNT_W'(DEPTH));

      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

      // A refused store is counted even when a pop frees a slot in the same cycle.
      if (i_wrEn && full_q && (drop_q != 8'hFF))
         drop_d = drop_q + 8'd1;

      case (state_q)
         IDLE: begin
            if (count_q != '0)
               state_d = gate ? DRAIN : WAIT;
         end
         WAIT: begin
            if (gate)
               state_d = DRAIN;
         end
         DRAIN: begin
            if (pop) begin
               if (count_d == '0)
                  state_d = IDLE;
               else if (!gate)
                  state_d = WAIT;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q  <= IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         drop_q   <= 8'd0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         full_q   <= full_d;
         drop_q   <= drop_d;
      end
   end

   always_ff @(posedge i_clk) begin
      if (push) begin
         addr_mem[wr_ptr_q] <= i_pxlAddr[ADDR_W+1:2];
         data_mem[wr_ptr_q] <= i_pxlData;
      end
   end

   // The head slot cannot be rewritten while DRAIN holds entries, so it stays stable on stall.
   assign o_fb_valid = (state_q == DRAIN);
   assign o_fb_addr  = o_fb_valid ? addr_mem[rd_ptr_q] : '0;
   assign o_fb_data  = o_fb_valid ? data_mem[rd_ptr_q] : '0;
   assign o_full     = full_q;
   assign o_count    = count_q;
   assign o_dropCnt  = drop_q;

endmodule
